// File: rtl/pbus_pkg.sv
// Shared types and constants for the host-parallel-bus to MMIO bridge.
package pbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_WAIT,
    ST_ACK
  } state_e;

  typedef enum logic {
    KIND_WR,
    KIND_RD
  } kind_e;

  localparam int DEF_A_W         = 6;
  localparam int DEF_MM_A_W      = 8;
  localparam int DEF_D_W         = 8;
  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_RD_LATENCY  = 1;

  localparam int               ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/pbus_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous host strobe.
module pbus_sync
  import pbus_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/pbus_mmio_bridge.sv
// Host strobe bus to single-cycle MMIO accesses, with level RDY acknowledge
// and a saturating protocol-error counter.
module pbus_mmio_bridge
  import pbus_pkg::*;
#(
  parameter int A_W         = DEF_A_W,
  parameter int MM_A_W      = DEF_MM_A_W,
  parameter int D_W         = DEF_D_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RD_LATENCY  = DEF_RD_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_cs_i,
  input  logic              bus_wr_i,
  input  logic              bus_rd_i,
  input  logic [A_W-1:0]    bus_a_i,
  input  logic [D_W-1:0]    bus_d_w_i,
  output logic [D_W-1:0]    bus_d_r_o,
  output logic              bus_rdy_o,
  output logic              mm_cs_o,
  output logic              mm_wr_o,
  output logic              mm_rd_o,
  output logic [MM_A_W-1:0] mm_addr_o,
  output logic [D_W-1:0]    mm_wdata_o,
  input  logic [D_W-1:0]    mm_rdata_i,
  output logic              busy_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  input  logic              err_clr_i
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  logic cs_s, wr_s, rd_s;

  pbus_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .rst_n(rst_n), .d_i(bus_cs_i), .q_o(cs_s));
  pbus_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (.clk(clk), .rst_n(rst_n), .d_i(bus_wr_i), .q_o(wr_s));
  pbus_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (.clk(clk), .rst_n(rst_n), .d_i(bus_rd_i), .q_o(rd_s));

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MM_A_W-1:0]  addr_q, addr_d;
  logic [D_W-1:0]     wdata_q, wdata_d;
  logic [D_W-1:0]     rdata_q, rdata_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               rdy_q;
  logic               cs_d_q, wr_d_q, rd_d_q;
  logic               wr_rise, rd_rise, wr_fall, rd_fall, err_ev;

  // Edges only count while the host holds chip select.
  assign wr_rise = cs_s &  wr_s & ~wr_d_q;
  assign rd_rise = cs_s &  rd_s & ~rd_d_q;
  assign wr_fall = cs_s & ~wr_s &  wr_d_q;
  assign rd_fall = cs_s & ~rd_s &  rd_d_q;
  assign err_ev  = (wr_rise & rd_rise) | ((wr_rise | rd_rise) & (state_q != ST_IDLE));

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_rise && !rd_rise) begin
          addr_d  = MM_A_W'(bus_a_i);
          wdata_d = bus_d_w_i;
          state_d = ST_WR_ISSUE;
        end else if (rd_rise && !wr_rise) begin
          addr_d  = MM_A_W'(bus_a_i);
          cnt_d   = '0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_ISSUE: begin
        kind_d  = KIND_WR;
        state_d = ST_ACK;
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RD_LATENCY)) begin
          rdata_d = mm_rdata_i;
          kind_d  = KIND_RD;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if ((kind_q == KIND_WR) ? wr_fall : rd_fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Losing cs abandons the transaction; read data from an aborted read is dropped.
    if (!cs_s && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      rdata_d = rdata_q;
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_clr_i)                     err_d = '0;
    else if (err_ev && err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_WR;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      rdy_q   <= 1'b0;
      cs_d_q  <= 1'b0;
      wr_d_q  <= 1'b0;
      rd_d_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rdy_q   <= (state_d == ST_ACK);
      cs_d_q  <= cs_s;
      wr_d_q  <= wr_s;
      rd_d_q  <= rd_s;
    end
  end

  assign bus_d_r_o  = rdata_q;
  assign bus_rdy_o  = rdy_q;
  assign mm_cs_o    = cs_d_q;
  assign mm_wr_o    = (state_q == ST_WR_ISSUE);
  assign mm_rd_o    = (state_q == ST_RD_WAIT) && (cnt_q == '0);
  assign mm_addr_o  = addr_q;
  assign mm_wdata_o = wdata_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_pbus_mmio_bridge.sv
// Randomised scoreboard bench: host-side tasks queue expected MMIO pulses and
// acknowledges; a monitor pops and compares; a register-file model answers reads.
module tb_pbus_mmio_bridge;

  localparam int SYNC = 3;
  localparam int RDL  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_cs_i = 1'b0, bus_wr_i = 1'b0, bus_rd_i = 1'b0;
  logic [5:0] bus_a_i = '0;
  logic [7:0] bus_d_w_i = '0;
  logic [7:0] bus_d_r_o;
  logic       bus_rdy_o, mm_cs_o, mm_wr_o, mm_rd_o, busy_o;
  logic [7:0] mm_addr_o, mm_wdata_o, err_cnt_o;
  logic [7:0] mm_rdata_i = '0;
  logic       err_clr_i = 1'b0;

  pbus_mmio_bridge #(.A_W(6), .MM_A_W(8), .D_W(8), .SYNC_STAGES(SYNC), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_cs_i(bus_cs_i), .bus_wr_i(bus_wr_i), .bus_rd_i(bus_rd_i),
    .bus_a_i(bus_a_i), .bus_d_w_i(bus_d_w_i), .bus_d_r_o(bus_d_r_o), .bus_rdy_o(bus_rdy_o),
    .mm_cs_o(mm_cs_o), .mm_wr_o(mm_wr_o), .mm_rd_o(mm_rd_o),
    .mm_addr_o(mm_addr_o), .mm_wdata_o(mm_wdata_o), .mm_rdata_i(mm_rdata_i),
    .busy_o(busy_o), .err_cnt_o(err_cnt_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [7:0] addr; logic [7:0] data; } mm_ev_t;
  typedef struct { bit is_rd; logic [7:0] data; } rsp_t;

  mm_ev_t     mmq[$];
  rsp_t       rspq[$];
  logic [7:0] mem[256];
  logic [7:0] shadow[64];
  int         n_tests = 0, n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Register file: writes land on mm_wr_o; read data is valid only in the
  // cycle RDL after the mm_rd_o pulse, inverted (wrong) data before that.
  initial begin
    int cd;
    logic [7:0] raddr;
    cd = 0; raddr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    forever begin
      @(negedge clk);
      mm_rdata_i = (cd > 0) ? ~mem[raddr] : 8'($urandom);
      if (cd == 1) mm_rdata_i = mem[raddr];
      if (cd > 0) cd--;
      if (mm_rd_o) begin cd = RDL; raddr = mm_addr_o; end
      if (mm_wr_o) mem[mm_addr_o] = mm_wdata_o;
    end
  end

  // Monitor: every MMIO pulse and every RDY rise must match a queued expectation.
  initial begin
    logic rdy_prev;
    mm_ev_t e;
    rsp_t r;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mm_wr_o || mm_rd_o) begin
        if (mmq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mm_unexpected: got pulse wr=%0b rd=%0b addr=0x%0h, expected none", mm_wr_o, mm_rd_o, mm_addr_o);
        end else begin
          e = mmq.pop_front();
          chk("mm_kind_wr", int'(mm_wr_o), int'(e.wr));
          chk("mm_kind_rd", int'(mm_rd_o), int'(!e.wr));
          chk("mm_addr", mm_addr_o, e.addr);
          if (e.wr) chk("mm_wdata", mm_wdata_o, e.data);
        end
      end
      if (bus_rdy_o && !rdy_prev) begin
        if (rspq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rdy_unexpected: got rdy=1, expected 0");
        end else begin
          r = rspq.pop_front();
          if (r.is_rd) chk("rd_data", bus_d_r_o, r.data);
        end
      end
      rdy_prev = bus_rdy_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_rdy(input bit lvl, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (bus_rdy_o !== lvl && cnt < 60);
  endtask

  task automatic access(bit is_wr, logic [5:0] a, logic [7:0] d);
    int cnt;
    mmq.push_back('{wr: is_wr, addr: 8'(a), data: d});
    rspq.push_back('{is_rd: !is_wr, data: shadow[a]});
    if (is_wr) shadow[a] = d;
    bus_a_i = a; bus_d_w_i = d;
    if (is_wr) bus_wr_i = 1'b1; else bus_rd_i = 1'b1;
    wait_rdy(1'b1, cnt);
    chk(is_wr ? "wr_rdy_latency" : "rd_rdy_latency", cnt, is_wr ? SYNC + 2 : SYNC + 2 + RDL);
    bus_wr_i = 1'b0; bus_rd_i = 1'b0;
    wait_rdy(1'b0, cnt);
    chk("rdy_drop_latency", cnt, SYNC + 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_rdy"}, bus_rdy_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_mm_wr"}, mm_wr_o, 0);
    chk({tag, "_mm_rd"}, mm_rd_o, 0);
    chk({tag, "_mm_cs"}, mm_cs_o, 0);
    chk({tag, "_addr"}, mm_addr_o, 0);
    chk({tag, "_wdata"}, mm_wdata_o, 0);
    chk({tag, "_drd"}, bus_d_r_o, 0);
    chk({tag, "_err"}, err_cnt_o, 0);
  endtask

  initial begin
    int seen, cnt;
    logic [7:0] prev;
    for (int i = 0; i < 64; i++) shadow[i] = 8'(i * 7 + 3);

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1; bus_cs_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("mm_cs_follow", mm_cs_o, 1);

    // Directed write / read-back.
    access(1'b1, 6'h05, 8'hA5);
    access(1'b1, 6'h21, 8'h3C);
    access(1'b0, 6'h21, 8'h00);
    access(1'b0, 6'h05, 8'h00);

    // Randomised traffic.
    for (int i = 0; i < 40; i++)
      access(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));

    // cs dropped during RD_WAIT: the pulse still happens, no acknowledge.
    access(1'b0, 6'h05, 8'h00);
    prev = shadow[5];
    mmq.push_back('{wr: 1'b0, addr: 8'h2A, data: 8'h00});
    bus_a_i = 6'h2A; bus_rd_i = 1'b1;
    @(negedge clk);
    bus_cs_i = 1'b0;
    seen = 0;
    repeat (15) begin @(negedge clk); if (bus_rdy_o) seen = 1; end
    chk("csdrop_rdy", seen, 0);
    chk("csdrop_keep_rdata", bus_d_r_o, prev);
    chk("csdrop_busy", busy_o, 0);
    chk("csdrop_mm_cs", mm_cs_o, 0);
    bus_rd_i = 1'b0;
    repeat (5) @(negedge clk);
    bus_cs_i = 1'b1;
    repeat (6) @(negedge clk);

    // Simultaneous strobes: error, no access.
    bus_wr_i = 1'b1; bus_rd_i = 1'b1;
    repeat (8) @(negedge clk);
    chk("simul_err", err_cnt_o, 1);
    chk("simul_busy", busy_o, 0);
    bus_wr_i = 1'b0; bus_rd_i = 1'b0;
    repeat (6) @(negedge clk);

    // Rise while in ACK: error, ACK held.
    mmq.push_back('{wr: 1'b0, addr: 8'h07, data: 8'h00});
    rspq.push_back('{is_rd: 1'b1, data: shadow[7]});
    bus_a_i = 6'h07; bus_rd_i = 1'b1;
    wait_rdy(1'b1, cnt);
    chk("ack_rd_latency", cnt, SYNC + 2 + RDL);
    bus_wr_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("ack_rise_err", err_cnt_o, 2);
    chk("ack_rise_rdy_held", bus_rdy_o, 1);
    bus_rd_i = 1'b0;
    wait_rdy(1'b0, cnt);
    chk("ack_rd_fall_latency", cnt, SYNC + 1);
    bus_wr_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("ack_err_stable", err_cnt_o, 2);

    // Clear in the very cycle a new error is detected: clear wins.
    bus_wr_i = 1'b1; bus_rd_i = 1'b1;
    repeat (SYNC) @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    chk("clr_priority", err_cnt_o, 0);
    repeat (4) @(negedge clk);
    chk("clr_after", err_cnt_o, 0);
    bus_wr_i = 1'b0; bus_rd_i = 1'b0;
    repeat (6) @(negedge clk);

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      bus_wr_i = 1'b1; bus_rd_i = 1'b1;
      repeat (5) @(negedge clk);
      bus_wr_i = 1'b0; bus_rd_i = 1'b0;
      repeat (5) @(negedge clk);
      if (i == 254) chk("sat_reach", err_cnt_o, 255);
    end
    chk("sat_hold", err_cnt_o, 255);

    // Reset during WR_ISSUE: the write is abandoned.
    bus_a_i = 6'h10; bus_d_w_i = 8'h99; bus_wr_i = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    rst_n = 1'b0; bus_wr_i = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    access(1'b0, 6'h10, 8'h00);
    access(1'b0, 6'h21, 8'h00);

    repeat (10) @(negedge clk);
    chk("mmq_drained", mmq.size(), 0);
    chk("rspq_drained", rspq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
